// File: rtl/mask_or_reduce_pipe.sv
// Two-stage valid/ready pipeline computing |((x|y)&z) per channel, with a saturating hit counter.
// Optional sticky per-channel hit flags are enabled by defining MASK_OR_REDUCE_STICKY_EN.
module mask_or_reduce_pipe #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_x,
    input  logic [CHANNELS*WIDTH-1:0] in_y,
    input  logic [CHANNELS*WIDTH-1:0] in_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       out_hit,
    output logic                      out_any,
    input  logic                      count_clr,
`ifdef MASK_OR_REDUCE_STICKY_EN
    input  logic                      sticky_clr,
    output logic [CHANNELS-1:0]       sticky_hit,
`endif
    output logic [CNT_W-1:0]          hit_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                      s1_valid_q, s1_valid_d;
    logic [CHANNELS*WIDTH-1:0] s1_m_q, s1_m_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [CHANNELS-1:0]       hit_q, hit_d;
    logic                      any_q, any_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0]       s1_red_s;
    logic                      s2_adv_s, s1_adv_s, out_xfer_s;

    assign s2_adv_s   = !s2_valid_q || out_ready;
    assign s1_adv_s   = !s1_valid_q || s2_adv_s;
    assign out_xfer_s = s2_valid_q && out_ready;
    assign in_ready   = s1_adv_s;
    assign out_valid  = s2_valid_q;
    assign out_hit    = hit_q;
    assign out_any    = any_q;
    assign hit_count  = cnt_q;

    // Per-channel OR-reduction of the stage-1 masked operands.
    always_comb begin
        s1_red_s = {CHANNELS{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            s1_red_s[k] = |s1_m_q[k*WIDTH +: WIDTH];
        end
    end

    // Next-state for both pipeline stages; data only loads alongside a valid beat.
    always_comb begin
        if (s1_adv_s) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s1_adv_s && in_valid) begin
            s1_m_d = (in_x | in_y) & in_z;
        end else begin
            s1_m_d = s1_m_q;
        end
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (s2_adv_s && s1_valid_q) begin
            hit_d = s1_red_s;
            any_d = |s1_red_s;
        end else begin
            hit_d = hit_q;
            any_d = any_q;
        end
    end

    // Saturating hit-transaction counter; clear beats a simultaneous increment.
    always_comb begin
        if (count_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (out_xfer_s && any_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_m_q     <= {(CHANNELS*WIDTH){1'b0}};
            s2_valid_q <= 1'b0;
            hit_q      <= {CHANNELS{1'b0}};
            any_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_m_q     <= s1_m_d;
            s2_valid_q <= s2_valid_d;
            hit_q      <= hit_d;
            any_q      <= any_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef MASK_OR_REDUCE_STICKY_EN
    logic [CHANNELS-1:0] sticky_q, sticky_d;

    assign sticky_hit = sticky_q;

    // Sticky flags: a transferred hit wins over a same-cycle clear.
    always_comb begin
        if (sticky_clr) begin
            sticky_d = {CHANNELS{1'b0}};
        end else begin
            sticky_d = sticky_q;
        end
        if (out_xfer_s) begin
            sticky_d = sticky_d | hit_q;
        end else begin
            sticky_d = sticky_d;
        end
    end

    // Sticky flag state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= {CHANNELS{1'b0}};
        end else begin
            sticky_q <= sticky_d;
        end
    end
`endif

endmodule

// File: tb/tb_mask_or_reduce_pipe.sv
// Randomized and directed bench for mask_or_reduce_pipe against a queue-based reference model.
// A second instance with CNT_W=2 exercises counter saturation on the same stimulus.
module tb_mask_or_reduce_pipe;
    localparam int W  = 4;
    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          count_clr = 1'b0;
    logic          sticky_clr = 1'b0;
    logic [CH*W-1:0] in_x = '0, in_y = '0, in_z = '0;
    logic          in_ready, out_valid, out_any;
    logic [CH-1:0] out_hit;
    logic [7:0]    hit_count;
    logic          b_in_ready, b_out_valid, b_out_any;
    logic [CH-1:0] b_out_hit;
    logic [1:0]    b_hit_count;
`ifdef MASK_OR_REDUCE_STICKY_EN
    logic [CH-1:0] sticky_hit, b_sticky_hit;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [CH-1:0] exp_q[$];
    int cnt = 0, cnt2 = 0, starve = 0;
    logic [CH-1:0] sticky_m = '0;

    always #5 clk = ~clk;

    mask_or_reduce_pipe #(.WIDTH(W), .CHANNELS(CH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid),
        .out_ready(out_ready), .out_hit(out_hit), .out_any(out_any),
        .count_clr(count_clr),
`ifdef MASK_OR_REDUCE_STICKY_EN
        .sticky_clr(sticky_clr), .sticky_hit(sticky_hit),
`endif
        .hit_count(hit_count)
    );

    mask_or_reduce_pipe #(.WIDTH(W), .CHANNELS(CH), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_hit(b_out_hit), .out_any(b_out_any),
        .count_clr(count_clr),
`ifdef MASK_OR_REDUCE_STICKY_EN
        .sticky_clr(sticky_clr), .sticky_hit(b_sticky_hit),
`endif
        .hit_count(b_hit_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CH-1:0] ref_hit(input logic [CH*W-1:0] x, input logic [CH*W-1:0] y,
                                              input logic [CH*W-1:0] z);
        logic [CH-1:0] r;
        int xv, yv, zv, msk;
        msk = (1 << W) - 1;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            xv = (int'(x) >> (k*W)) & msk;
            yv = (int'(y) >> (k*W)) & msk;
            zv = (int'(z) >> (k*W)) & msk;
            r[k] = (((xv | yv) & zv) != 0);
        end
        return r;
    endfunction

    // One clock: drive inputs, check observable state, then advance the model at the edge.
    task automatic step(input logic v, input logic [CH*W-1:0] x, input logic [CH*W-1:0] y,
                        input logic [CH*W-1:0] z, input logic ordy, input logic clr,
                        input logic sclr);
        logic in_xfer, out_xfer;
        logic [CH-1:0] f;
        in_valid = v; in_x = x; in_y = y; in_z = z;
        out_ready = ordy; count_clr = clr; sticky_clr = sclr;
        #1;
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
        check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
        if (exp_q.size() == 0) begin
            check("empty_valid", 32'(out_valid), 32'd0);
        end else if (out_valid) begin
            check("out_hit", 32'(out_hit), 32'(exp_q[0]));
            check("out_any", 32'(out_any), 32'(|exp_q[0]));
            check("b_out_hit", 32'(b_out_hit), 32'(exp_q[0]));
        end
        if (exp_q.size() > 0 && !out_valid) starve++;
        else starve = 0;
        if (starve > 1) check("latency", 32'(out_valid), 32'd1);
        check("hit_count", 32'(hit_count), 32'(cnt));
        check("hit_count_c2", 32'(b_hit_count), 32'(cnt2));
`ifdef MASK_OR_REDUCE_STICKY_EN
        check("sticky_hit", 32'(sticky_hit), 32'(sticky_m));
`endif
        f = '0;
        @(posedge clk);
        if (out_xfer) f = exp_q.pop_front();
        if (in_xfer) exp_q.push_back(ref_hit(x, y, z));
        if (clr) begin
            cnt = 0; cnt2 = 0;
        end else if (out_xfer && (|f)) begin
            cnt  = (cnt  < 255) ? cnt  + 1 : 255;
            cnt2 = (cnt2 < 3)   ? cnt2 + 1 : 3;
        end
        if (sclr) sticky_m = '0;
        if (out_xfer) sticky_m = sticky_m | f;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_hit", 32'(out_hit), 32'd0);
        check("rst_any", 32'(out_any), 32'd0);
        check("rst_count", 32'(hit_count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single beat: ch0 (12|15)&7 hits, ch1 masked to zero.
        step(1'b1, {4'd0, 4'd12}, {4'd0, 4'd15}, {4'd15, 4'd7}, 1'b1, 1'b0, 1'b0);
        check("t1_lat", 32'(out_valid), 32'd0);
        idle(1'b1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_hit", 32'(out_hit), 32'd1);
        check("t1_any", 32'(out_any), 32'd1);
        idle(1'b1);
        check("t1_count", 32'(hit_count), 32'd1);

        // Streaming beats with z=0 never hit.
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 8'($urandom), 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (2) idle(1'b1);
        check("t2_count", 32'(hit_count), 32'd1);

        // Backpressure: third beat must be refused until the sink accepts.
        for (int i = 0; i < 2; i++) step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        check("t3_ready", 32'(in_ready), 32'd0);
        repeat (3) step(1'b1, 8'h3c, 8'h00, 8'hff, 1'b0, 1'b0, 1'b0);
        repeat (4) idle(1'b1);
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // Counter saturation and clear priority.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h11, 8'h00, 8'hff, 1'b1, 1'b0, 1'b0);
        repeat (2) idle(1'b1);
        check("t4_sat", 32'(b_hit_count), 32'd3);
        step(1'b1, 8'h11, 8'h00, 8'hff, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        check("t4_clr", 32'(hit_count), 32'd0);
        check("t4_clr_c2", 32'(b_hit_count), 32'd0);

`ifdef MASK_OR_REDUCE_STICKY_EN
        step(1'b1, 8'h00, {4'd1, 4'd0}, {4'hf, 4'h0}, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hff, 8'hff, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (2) idle(1'b1);
        check("t6_hold", 32'(sticky_hit), 32'h2);
        step(1'b1, 8'h00, {4'd1, 4'd0}, {4'hf, 4'h0}, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        check("t6_setwins", 32'(sticky_hit), 32'h2);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        check("t6_clr", 32'(sticky_hit), 32'h0);
`endif

        // Randomized traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 15) == 0));
        end

        // Reset with beats in flight discards them at once.
        for (int i = 0; i < 2; i++) step(1'b1, 8'h11, 8'h11, 8'hff, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_count", 32'(hit_count), 32'd0);
        check("t5_count_c2", 32'(b_hit_count), 32'd0);
        exp_q.delete();
        cnt = 0; cnt2 = 0; sticky_m = '0; starve = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) idle(1'b1);

        repeat (6) idle(1'b1);
        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mask_or_reduce_pipe.md
Name: mask_or_reduce_pipe

Overview:
- Multi-channel, pipelined form of the masked OR-reduction `|((x | y) & z)`.
- Each channel takes three WIDTH-bit operands and produces one hit bit.
- Results leave a 2-stage valid/ready pipeline with full backpressure, plus a saturating count of transactions that contained any hit.
- Sits in the expression/operator test blocks as a synthesizable, handshaked reduction engine.

Parameters:
- WIDTH, 4, operand width per channel (>=1)
- CHANNELS, 2, number of independent channels (>=1)
- CNT_W, 8, width of the hit-transaction counter (>=1)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  pipeline can accept a beat
- in_x  input  CHANNELS*WIDTH  x operands; channel k at bits [k*WIDTH +: WIDTH]
- in_y  input  CHANNELS*WIDTH  y operands, same packing
- in_z  input  CHANNELS*WIDTH  z mask operands, same packing
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- out_hit  output  CHANNELS  per-channel result `|((x|y)&z)`
- out_any  output  1  OR of out_hit
- hit_count  output  CNT_W  number of accepted output beats with out_any=1, saturating
- count_clr  input  1  synchronous clear of hit_count

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset: all valid flags, out_hit, out_any and hit_count go to 0.
  - in_ready is 1 after reset because the pipeline is empty.
  - Asserting rst mid-operation discards all in-flight beats immediately.
- Stage 1 (S1), registered:
  - Per channel, m_k = (x_k | y_k) & z_k, WIDTH bits.
  - s1_valid is set when a beat is accepted.
- Stage 2 (S2), registered:
  - out_hit[k] = |m_k.
  - out_any = |out_hit.
  - out_valid = s2_valid.
- Latency: the beat accepted at edge N appears on out_* after edge N+1 (2 registers), provided there is no stall.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no skid buffer is used.
  - S2 loads from S1 when s2_adv: s2_valid <= s1_valid.
  - S1 loads from the input when s1_adv: s1_valid <= in_valid.
  - A full pipe with out_ready=0 holds all data and in_ready=0.
  - Simultaneous input and output transfer in a full pipe sustains 1 beat/cycle.
- Stability: out_hit and out_any must not change while out_valid=1 and out_ready=0.
- hit_count:
  - Increments by 1 on each output transfer with out_any=1.
  - Saturates at 2^CNT_W-1, with no wrap.
  - count_clr has priority over an increment in the same cycle; the result is 0.
- Width rules: all operands are unsigned, with no extension between channels. WIDTH=1 degenerates to (x|y)&z.
- X-safety: data registers need not load when the matching valid is 0, but out_* must be 0 after reset.

Optional Feature:
- Macro: MASK_OR_REDUCE_STICKY_EN.
- When defined:
  - Adds output sticky_hit (CHANNELS bits) and input sticky_clr (1 bit).
  - sticky_hit[k] sets on any output transfer with out_hit[k]=1.
  - sticky_hit clears on sticky_clr; the set wins over the clear in the same cycle.
  - sticky_hit resets to 0 on rst.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
1. WIDTH=4, CHANNELS=2, out_ready=1, one beat with ch0 x=12 y=15 z=7 and ch1 x=0 y=0 z=15 -> out_valid two cycles later, out_hit=2'b01, out_any=1, hit_count=1.
2. Continuous stream of 8 beats, all z=0 -> 8 consecutive out_valid cycles, out_hit=0, out_any=0, hit_count stays 0, in_ready stays 1.
3. Backpressure: 3 beats with out_ready=0:
   - in_ready drops to 0 after 2 beats are accepted.
   - out_hit is held stable.
   - Raising out_ready drains the beats in order with no loss or duplication.
4. CNT_W=2, 5 hit beats -> hit_count reads 1, 2, 3, 3, 3; count_clr asserted together with a hit beat -> 0.
5. rst asserted while 2 beats are in flight -> out_valid=0 and hit_count=0 immediately; no stale beat appears after rst deasserts.
6. With MASK_OR_REDUCE_STICKY_EN: a ch1 hit followed by 3 non-hit beats -> sticky_hit=2'b10 is held; sticky_clr together with a new ch1 hit -> stays 2'b10; sticky_clr alone -> 0.
